alu_serial_ctrl: RTL

Bit-serial ALU sequencer that drives a single external 1-bit ALU slice (a/b/cin/less_greater_equal/control/bonus in, result/cout out) one bit per clock, LSB first. It assembles a WIDTH-bit result, carry, zero and overflow flags. For set-on-compare operations it runs the subtraction chain, derives the comparison flag, then issues a final compare cycle on bit 0. It sits between the datapath's operand/control registers and one slice instance, trading area for latency.

---
 rtl/alu_serial_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer that drives one external 1-bit
// ALU slice LSB-first and assembles the full-width result and flags.
// Set-on-compare runs the subtraction chain, derives the compare flag, then
// issues one extra compare cycle on bit 0.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_ctrl,
  input  logic [2:0]       bonus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_less,
  output logic [3:0]       slice_control,
  output logic [2:0]       slice_bonus,
  input  logic             slice_result,
  input  logic             slice_cout
);
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, SET, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [2:0]       bonus_q, bonus_d;
  logic             c_q, c_d;          // running carry between bit cycles
  logic             cmsb_q, cmsb_d;    // carry into the MSB (for compare V)
  logic             n_q, n_d;          // MSB difference bit (compare N)
  logic             z_q, z_d;          // all difference bits zero (compare Z)
  logic             cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;

  logic is_cmp, is_arith, d_bit, lt, flag, supported;

  // Registered state; everything clears on reset so no done escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ctrl_q  <= '0;
      bonus_q <= '0;
      c_q     <= 1'b0;
      cmsb_q  <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ctrl_q  <= ctrl_d;
      bonus_q <= bonus_d;
      c_q     <= c_d;
      cmsb_q  <= cmsb_d;
      n_q     <= n_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, slice drive and result/flag assembly.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ctrl_d  = ctrl_q;
    bonus_d = bonus_q;
    c_d     = c_q;
    cmsb_d  = cmsb_q;
    n_d     = n_q;
    z_d     = z_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;

    slice_a       = 1'b0;
    slice_b       = 1'b0;
    slice_cin     = 1'b0;
    slice_less    = 1'b0;
    slice_control = 4'b0000;
    slice_bonus   = 3'b000;

    is_cmp   = (ctrl_q == 4'b0111);
    is_arith = (ctrl_q == 4'b0010) || (ctrl_q == 4'b0110);
    d_bit    = a_q[idx_q] ^ ~b_q[idx_q] ^ c_q;

    // Signed less-than from the subtraction: N xor V.
    lt = n_q ^ (cmsb_q ^ c_q);
    case (bonus_q)
      3'b000:  flag = lt;
      3'b001:  flag = ~lt & ~z_q;
      3'b010:  flag = lt | z_q;
      3'b011:  flag = ~lt;
      3'b110:  flag = z_q;
      3'b100:  flag = ~z_q;
      default: flag = 1'b0;
    endcase

    case (alu_ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1101: supported = 1'b1;
      4'b0111: supported = (bonus != 3'b101) && (bonus != 3'b111);
      default: supported = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = src1;
          b_d     = src2;
          ctrl_d  = alu_ctrl;
          bonus_d = bonus;
          idx_d   = '0;
          res_d   = '0;
          c_d     = (alu_ctrl == 4'b0110) || (alu_ctrl == 4'b0111);
          cmsb_d  = 1'b0;
          n_d     = 1'b0;
          z_d     = 1'b1;
          cout_d  = 1'b0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = supported ? RUN : DONE;
        end
      end
      RUN: begin
        slice_a       = a_q[idx_q];
        slice_b       = b_q[idx_q];
        slice_cin     = c_q;
        slice_control = is_cmp ? 4'b0110 : ctrl_q;
        slice_bonus   = bonus_q;
        res_d[idx_q]  = slice_result;
        c_d           = slice_cout;
        z_d           = z_q & ~d_bit;
        if (idx_q == LAST) begin
          cmsb_d = c_q;
          n_d    = d_bit;
          if (is_arith || is_cmp) cout_d = slice_cout;
          if (is_arith)           ovf_d  = c_q ^ slice_cout;
          zero_d  = (res_d == '0);
          state_d = is_cmp ? SET : DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SET: begin
        slice_a       = a_q[0];
        slice_b       = b_q[0];
        slice_cin     = 1'b1;
        slice_less    = flag;
        slice_control = 4'b0111;
        slice_bonus   = bonus_q;
        res_d         = {{(WIDTH-1){1'b0}}, slice_result};
        ovf_d         = 1'b0;
        zero_d        = ~slice_result;
        state_d       = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == RUN) || (state_q == SET);
  assign done     = (state_q == DONE);
  assign result   = res_q;
  assign cout     = cout_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
endmodule
